// File: rtl/v810_exc_ctrl.sv
// V810 exception/interrupt sequencer: arbitrates exception, NMI, IRQ and RETI,
// commits the system-register save/restore and serves LDSR/STSR.
package v810_exc_pkg;

  typedef enum logic [4:0] {
    SR_EIPC  = 5'd0,
    SR_EIPSW = 5'd1,
    SR_FEPC  = 5'd2,
    SR_FEPSW = 5'd3,
    SR_ECR   = 5'd4,
    SR_PSW   = 5'd5,
    SR_PIR   = 5'd6,
    SR_TKCW  = 5'd7,
    SR_CHCW  = 5'd24,
    SR_ADTRE = 5'd25
  } sr_sel_t;

  typedef struct packed {
    logic [11:0] rfu20;
    logic [3:0]  i;
    logic        np;
    logic        ep;
    logic        ae;
    logic        id;
    logic [1:0]  rfu10;
    logic        fro;
    logic        fiv;
    logic        fzd;
    logic        fov;
    logic        fud;
    logic        fpr;
    logic        cy;
    logic        ov;
    logic        s;
    logic        z;
  } psw_t;

  typedef struct packed {
    logic cy;
    logic ov;
    logic s;
    logic z;
  } aluflags_t;

  typedef struct packed {
    logic [15:0] fecc;
    logic [15:0] eicc;
  } ecr_t;

endpackage

module v810_exc_ctrl
  import v810_exc_pkg::*;
#(
  parameter logic [15:0] PIR_VALUE  = 16'h8100,
  parameter logic [31:0] TKCW_VALUE = 32'h000000E0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] pc_in,
  input  logic        exc_req,
  input  logic [15:0] exc_code,
  output logic        exc_ack,
  input  logic        nmi_req,
  output logic        nmi_ack,
  input  logic        irq_req,
  input  logic [3:0]  irq_level,
  output logic        irq_ack,
  input  logic        reti_req,
  output logic        reti_ack,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic        halt,
  output logic [15:0] fatal_code,
  input  logic [4:0]  sr_sel,
  input  logic        sr_we,
  input  logic [31:0] sr_wdata,
  output logic [31:0] sr_rdata,
  input  logic        fl_we,
  input  logic [3:0]  fl_in,
  output logic [31:0] psw
);

  typedef enum logic [2:0] {RSTV, IDLE, SAVE, VEC, FATAL} state_t;
  typedef enum logic [1:0] {K_EXC, K_NMI, K_IRQ, K_RETI} kind_t;

  state_t      state;
  kind_t       kind_q;
  psw_t        psw_q, eipsw_q, fepsw_q;
  ecr_t        ecr_q;
  logic [31:0] eipc_q, fepc_q, adtre_q, pc_q, target_q;
  logic [15:0] code_q, fatal_code_q;
  logic [3:0]  level_q;

  logic        idle, nmi_ok, irq_ok, accept;
  logic [15:0] irq_cc;
  logic [3:0]  irq_i;
  aluflags_t   fl;

  function automatic psw_t clean_psw(input logic [31:0] v);
    psw_t p;
    p       = psw_t'(v);
    p.rfu20 = '0;
    p.rfu10 = '0;
    return p;
  endfunction

  assign idle   = (state == IDLE);
  assign fl     = aluflags_t'(fl_in);
  assign irq_cc = {8'hFE, level_q, 4'h0};
  assign irq_i  = (level_q == 4'hF) ? 4'hF : 4'(level_q + 4'd1);

  // Winner is the highest-priority request that is currently eligible
  always_comb begin
    nmi_ok   = nmi_req && !psw_q.np;
    irq_ok   = irq_req && !psw_q.np && !psw_q.ep && !psw_q.id && (irq_level >= psw_q.i);
    exc_ack  = idle && exc_req;
    nmi_ack  = idle && !exc_req && nmi_ok;
    irq_ack  = idle && !exc_req && !nmi_ok && irq_ok;
    reti_ack = idle && !exc_req && !nmi_ok && !irq_ok && reti_req;
    accept   = exc_ack || nmi_ack || irq_ack || reti_ack;
  end

  always_comb begin
    sr_rdata = '0;
    case (sr_sel_t'(sr_sel))
      SR_EIPC:  sr_rdata = eipc_q;
      SR_EIPSW: sr_rdata = eipsw_q;
      SR_FEPC:  sr_rdata = fepc_q;
      SR_FEPSW: sr_rdata = fepsw_q;
      SR_ECR:   sr_rdata = ecr_q;
      SR_PSW:   sr_rdata = psw_q;
      SR_PIR:   sr_rdata = {16'h0000, PIR_VALUE};
      SR_TKCW:  sr_rdata = TKCW_VALUE;
      SR_ADTRE: sr_rdata = adtre_q;
      default:  sr_rdata = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= RSTV;
      kind_q       <= K_EXC;
      psw_q        <= psw_t'(32'h0000_8000);
      eipsw_q      <= '0;
      fepsw_q      <= '0;
      ecr_q        <= ecr_t'(32'h0000_FFF0);
      eipc_q       <= '0;
      fepc_q       <= '0;
      adtre_q      <= '0;
      pc_q         <= '0;
      target_q     <= '0;
      code_q       <= '0;
      fatal_code_q <= '0;
      level_q      <= '0;
    end else begin
      case (state)
        RSTV: state <= IDLE;
        IDLE: begin
          if (accept) begin
            pc_q    <= pc_in;
            code_q  <= exc_code;
            level_q <= irq_level;
            kind_q  <= exc_ack ? K_EXC : nmi_ack ? K_NMI : irq_ack ? K_IRQ : K_RETI;
            if (exc_ack && psw_q.np) begin
              fatal_code_q <= exc_code;
              state        <= FATAL;
            end else begin
              state <= SAVE;
            end
          end else begin
            // Explicit LDSR to PSW overrides a same-cycle flag update
            if (fl_we && !(sr_we && sr_sel_t'(sr_sel) == SR_PSW)) begin
              psw_q.cy <= fl.cy;
              psw_q.ov <= fl.ov;
              psw_q.s  <= fl.s;
              psw_q.z  <= fl.z;
            end
            if (sr_we) begin
              case (sr_sel_t'(sr_sel))
                SR_EIPC:  eipc_q  <= sr_wdata;
                SR_EIPSW: eipsw_q <= clean_psw(sr_wdata);
                SR_FEPC:  fepc_q  <= sr_wdata;
                SR_FEPSW: fepsw_q <= clean_psw(sr_wdata);
                SR_PSW:   psw_q   <= clean_psw(sr_wdata);
                SR_ADTRE: adtre_q <= sr_wdata;
                default:  ;
              endcase
            end
          end
        end
        SAVE: begin
          state <= VEC;
          case (kind_q)
            K_IRQ: begin
              eipc_q     <= pc_q;
              eipsw_q    <= psw_q;
              ecr_q.eicc <= irq_cc;
              psw_q.ep   <= 1'b1;
              psw_q.id   <= 1'b1;
              psw_q.ae   <= 1'b0;
              psw_q.i    <= irq_i;
              target_q   <= {16'hFFFF, irq_cc};
            end
            K_EXC: begin
              if (!psw_q.ep) begin
                eipc_q     <= pc_q;
                eipsw_q    <= psw_q;
                ecr_q.eicc <= code_q;
                psw_q.ep   <= 1'b1;
                target_q   <= {16'hFFFF, code_q[15:4], 4'h0};
              end else begin
                fepc_q     <= pc_q;
                fepsw_q    <= psw_q;
                ecr_q.fecc <= code_q;
                psw_q.np   <= 1'b1;
                target_q   <= 32'hFFFF_FFD0;
              end
              psw_q.id <= 1'b1;
              psw_q.ae <= 1'b0;
            end
            K_NMI: begin
              fepc_q     <= pc_q;
              fepsw_q    <= psw_q;
              ecr_q.fecc <= 16'hFFD0;
              psw_q.np   <= 1'b1;
              psw_q.id   <= 1'b1;
              psw_q.ae   <= 1'b0;
              target_q   <= 32'hFFFF_FFD0;
            end
            default: begin
              if (psw_q.np) begin
                psw_q    <= fepsw_q;
                target_q <= fepc_q;
              end else begin
                psw_q    <= eipsw_q;
                target_q <= eipc_q;
              end
            end
          endcase
        end
        VEC:     state <= IDLE;
        FATAL:   state <= FATAL;
        default: state <= IDLE;
      endcase
    end
  end

  assign redirect    = ((state == RSTV) && !RESET) || (state == VEC);
  assign redirect_pc = (state == RSTV) ? 32'hFFFF_FFF0 : target_q;
  assign busy        = (state != IDLE);
  assign halt        = (state == FATAL);
  assign fatal_code  = fatal_code_q;
  assign psw         = psw_q;

endmodule
